// File: rtl/spi_ram_responder.sv
// rtl/spi_ram_responder.sv - SPI mode-0 SRAM responder (03 read / 02 write, 24-bit address)
// All SPI pins are oversampled in the clk domain; the byte array is not reset.
module spi_ram_responder #(
  parameter int ADDR_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sck,
  input  logic cs_n,
  input  logic mosi,
  output logic miso,
  output logic miso_oe,
  output logic busy
);
  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_READ, S_WRITE, S_IGNORE
  } state_e;

  logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sck_prev_q, cs_prev_q;
  logic [SYNC_STAGES:0]   settle_q;
  logic                   armed_q, armed_d;

  state_e                 state_q, state_d;
  logic [4:0]             cnt_q, cnt_d;
  logic [7:0]             rx_q, rx_d, tx_q, tx_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic                   is_read_q, is_read_d;
  logic                   miso_q, miso_d, oe_q, oe_d, busy_q, busy_d;

  logic [7:0]             mem_q [DEPTH];

  logic                   sck_s, cs_s, mosi_s;
  logic                   sck_rise, sck_fall, cs_rise, cs_fall;
  logic [7:0]             rx_next;
  logic [ADDR_BITS-1:0]   addr_inc, addr_shift, load_addr;
  logic                   wr_en;
  logic [7:0]             load_data;

  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // cs_n falls are only trusted once the synchronizer has flushed its reset
  // value and cs_n was seen high, so reset inside a transaction cannot restart it.
  assign armed_d  = armed_q | (settle_q[SYNC_STAGES] & cs_s);
  assign cs_fall  = armed_q & cs_prev_q & ~cs_s;
  assign cs_rise  = ~cs_prev_q & cs_s;
  assign sck_rise = ~sck_prev_q & sck_s & ~cs_s;
  assign sck_fall = sck_prev_q & ~sck_s & ~cs_s;

  assign rx_next    = {rx_q[6:0], mosi_s};
  assign addr_inc   = addr_q + ADDR_BITS'(1);
  assign addr_shift = {addr_q[ADDR_BITS-2:0], mosi_s};
  assign load_addr  = (state_q == S_ADDR) ? addr_shift : addr_inc;
  assign wr_en      = ~reset & (state_q == S_WRITE) & sck_rise & (cnt_q == 5'd7);
  // Same-cycle write to the byte being loaded forwards the new value.
  assign load_data  = (wr_en && (addr_q == load_addr)) ? rx_next : mem_q[load_addr];

  always_ff @(posedge clk) begin
    if (reset) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b1;
      settle_q    <= '0;
      armed_q     <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sck_prev_q  <= sck_s;
      cs_prev_q   <= cs_s;
      settle_q    <= {settle_q[SYNC_STAGES-1:0], 1'b1};
      armed_q     <= armed_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[addr_q] <= rx_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      addr_q    <= '0;
      is_read_q <= 1'b0;
      miso_q    <= 1'b0;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      addr_q    <= addr_d;
      is_read_q <= is_read_d;
      miso_q    <= miso_d;
      oe_q      <= oe_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    addr_d    = addr_q;
    is_read_d = is_read_q;
    miso_d    = miso_q;
    oe_d      = oe_q;
    busy_d    = busy_q;

    case (state_q)
      S_IDLE: begin
        if (cs_fall) begin
          state_d = S_CMD;
          cnt_d   = '0;
          rx_d    = '0;
          busy_d  = 1'b1;
        end
      end
      S_CMD: begin
        if (sck_rise) begin
          rx_d  = rx_next;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd7) begin
            cnt_d = '0;
            if (rx_next == 8'h03) begin
              state_d   = S_ADDR;
              is_read_d = 1'b1;
            end else if (rx_next == 8'h02) begin
              state_d   = S_ADDR;
              is_read_d = 1'b0;
            end else begin
              state_d = S_IGNORE;
            end
          end
        end
      end
      S_ADDR: begin
        if (sck_rise) begin
          addr_d = addr_shift;
          cnt_d  = cnt_q + 5'd1;
          if (cnt_q == 5'd23) begin
            cnt_d = '0;
            if (is_read_q) begin
              state_d = S_READ;
              tx_d    = load_data;
            end else begin
              state_d = S_WRITE;
            end
          end
        end
      end
      S_READ: begin
        if (sck_fall) begin
          miso_d = tx_q[7];
          oe_d   = 1'b1;
          tx_d   = {tx_q[6:0], 1'b0};
          cnt_d  = cnt_q + 5'd1;
          if (cnt_q == 5'd7) begin
            cnt_d  = '0;
            addr_d = addr_inc;
            tx_d   = load_data;
          end
        end
      end
      S_WRITE: begin
        if (sck_rise) begin
          rx_d  = rx_next;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd7) begin
            cnt_d  = '0;
            addr_d = addr_inc;
          end
        end
      end
      S_IGNORE: begin
      end
      default: state_d = S_IDLE;
    endcase

    if (cs_rise) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      miso_d  = 1'b0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end
  end

  assign miso    = miso_q;
  assign miso_oe = oe_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_spi_ram_responder.sv
// tb/tb_spi_ram_responder.sv - directed bench for spi_ram_responder
// SCK half-period is 8 clk; miso is sampled 4 clk before each rising sck.
module tb_spi_ram_responder;
  logic clk = 1'b0;
  logic reset, sck, cs_n, mosi;
  logic miso, miso_oe, busy;
  int checks = 0;
  int errors = 0;
  int oe_seen = 0;
  logic [7:0] b0, b1, d;

  spi_ram_responder #(.ADDR_BITS(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .sck(sck), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      mosi = tx[i];
      tick(4);
      rx[i] = miso;
      if (miso_oe) oe_seen++;
      sck = 1'b1;
      tick(8);
      sck = 1'b0;
      tick(4);
    end
  endtask

  task automatic hdr(input logic [7:0] cmd, input logic [23:0] a);
    logic [7:0] x;
    cs_n = 1'b0;
    tick(8);
    xfer(cmd, 8, x);
    xfer(a[23:16], 8, x);
    xfer(a[15:8], 8, x);
    xfer(a[7:0], 8, x);
  endtask

  task automatic deselect();
    tick(4);
    cs_n = 1'b1;
    tick(12);
  endtask

  task automatic wr1(input logic [23:0] a, input logic [7:0] v);
    logic [7:0] x;
    hdr(8'h02, a);
    xfer(v, 8, x);
    deselect();
  endtask

  task automatic rd1(input logic [23:0] a, output logic [7:0] v);
    hdr(8'h03, a);
    xfer(8'h00, 8, v);
    deselect();
  endtask

  initial begin
    reset = 1'b1; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    tick(3);
    check("reset_miso", 32'(miso), 32'h0);
    check("reset_oe", 32'(miso_oe), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    tick(6);

    hdr(8'h02, 24'h000010);
    xfer(8'hA5, 8, d);
    xfer(8'h3C, 8, d);
    deselect();
    oe_seen = 0;
    hdr(8'h03, 24'h000010);
    check("rd_hdr_oe", oe_seen, 0);
    xfer(8'h00, 8, b0);
    xfer(8'h00, 8, b1);
    check("rd_byte0", 32'(b0), 32'hA5);
    check("rd_byte1", 32'(b1), 32'h3C);
    check("rd_data_oe", oe_seen, 16);
    check("rd_busy", 32'(busy), 32'h1);
    deselect();
    check("end_busy", 32'(busy), 32'h0);
    check("end_oe", 32'(miso_oe), 32'h0);
    check("end_miso", 32'(miso), 32'h0);

    hdr(8'h02, 24'h0000FF);
    xfer(8'h11, 8, d);
    xfer(8'h22, 8, d);
    deselect();
    rd1(24'h000000, b0);
    check("wrap_wr_00", 32'(b0), 32'h22);
    rd1(24'h0000FF, b0);
    check("wrap_wr_ff", 32'(b0), 32'h11);
    hdr(8'h03, 24'h0000FF);
    xfer(8'h00, 8, b0);
    xfer(8'h00, 8, b1);
    deselect();
    check("wrap_rd_b0", 32'(b0), 32'h11);
    check("wrap_rd_b1", 32'(b1), 32'h22);

    wr1(24'h123410, 8'h77);
    hdr(8'h03, 24'h000010);
    xfer(8'h00, 8, b0);
    xfer(8'h00, 8, b1);
    deselect();
    check("alias_b0", 32'(b0), 32'h77);
    check("alias_b1", 32'(b1), 32'h3C);

    oe_seen = 0;
    hdr(8'h9F, 24'h020000);
    xfer(8'h10, 8, d);
    check("ign_oe", oe_seen, 0);
    check("ign_busy", 32'(busy), 32'h1);
    deselect();
    check("ign_end_busy", 32'(busy), 32'h0);
    rd1(24'h000010, b0);
    check("ign_mem", 32'(b0), 32'h77);

    wr1(24'h000020, 8'hC3);
    hdr(8'h02, 24'h000020);
    xfer(8'hA0, 4, d);
    deselect();
    rd1(24'h000020, b0);
    check("partial_mem", 32'(b0), 32'hC3);

    for (int i = 0; i < 8; i++) begin
      mosi = i[0];
      sck = 1'b1;
      tick(8);
      sck = 1'b0;
      tick(8);
    end
    check("idle_sck_busy", 32'(busy), 32'h0);
    rd1(24'h000020, b0);
    check("idle_sck_mem", 32'(b0), 32'hC3);

    cs_n = 1'b0;
    tick(8);
    xfer(8'h02, 8, d);
    xfer(8'h00, 8, d);
    reset = 1'b1;
    tick(2);
    check("abort_miso", 32'(miso), 32'h0);
    check("abort_oe", 32'(miso_oe), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    tick(10);
    check("abort_no_restart", 32'(busy), 32'h0);
    cs_n = 1'b1;
    tick(12);
    wr1(24'h000030, 8'h5A);
    rd1(24'h000030, b0);
    check("abort_then_rw", 32'(b0), 32'h5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
